// File: rtl/omnivision_spi_frame_ctrl_pkg.sv
// Shared types and constants for the Omnivision SPI frame sequencer.
// Header layout: SYNC0 SYNC1 SYNC2 mode rows_hi rows_lo cols_hi cols_lo.
package omnivision_spi_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      HEADER     = 2'd2,
      DATA       = 2'd3
   } state_t;

   localparam logic [7:0] HDR_SYNC0 = 8'hFF;
   localparam logic [7:0] HDR_SYNC1 = 8'hFF;
   localparam logic [7:0] HDR_SYNC2 = 8'h00;
   localparam logic [7:0] MODE_RAW8 = 8'h2A;
   localparam int         HDR_LEN   = 8;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/omnivision_spi_hdr_mux.sv
// Combinational header byte select from the header index and latched geometry.
// Zero latency; no flow control.
module omnivision_spi_hdr_mux
   import omnivision_spi_frame_ctrl_pkg::*;
(
   input  logic [2:0]  hdr_idx,
   input  logic [7:0]  mode_l,
   input  logic [15:0] rows_l,
   input  logic [15:0] cols_l,
   output logic [7:0]  hdr_byte
);

   always_comb begin
      hdr_byte = HDR_SYNC0;
      case (hdr_idx)
         3'd0:    hdr_byte = HDR_SYNC0;
         3'd1:    hdr_byte = HDR_SYNC1;
         3'd2:    hdr_byte = HDR_SYNC2;
         3'd3:    hdr_byte = mode_l;
         3'd4:    hdr_byte = rows_l[15:8];
         3'd5:    hdr_byte = rows_l[7:0];
         3'd6:    hdr_byte = cols_l[15:8];
         default: hdr_byte = cols_l[7:0];
      endcase
   end

endmodule

// File: rtl/omnivision_spi_frame_ctrl.sv
// Frame sequencer: 8-byte header then one byte per pixel, registered, 1-cycle latency.
// No backpressure: the serializer must accept a byte every pixclk that tx_valid is high.
module omnivision_spi_frame_ctrl
   import omnivision_spi_frame_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 10,
   parameter int HDR_LEN    = 8
) (
   input  logic                  pixclk,
   input  logic                  reset,
   input  logic                  enable_req,
   input  logic [7:0]            mode,
   input  logic [15:0]           num_rows,
   input  logic [15:0]           num_cols,
   input  logic                  fv,
   input  logic                  lv,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  err_clear,
   output logic [7:0]            tx_byte,
   output logic                  tx_valid,
   output logic                  tx_header,
   output logic                  frame_active,
   output logic                  frame_done,
   output logic [15:0]           row_count,
   output logic [15:0]           col_count,
   output logic                  err_cols,
   output logic                  err_rows,
   output logic                  err_overlap,
   output logic [15:0]           frames_sent
);

   state_t      state, state_n;
   logic        fv_d, lv_d;
   logic [2:0]  hdr_idx, hdr_idx_n;
   logic        fall_pend, fall_pend_n;
   logic [7:0]  mode_l, mode_l_n;
   logic [15:0] rows_l, rows_l_n, cols_l, cols_l_n;
   logic [7:0]  tx_byte_n, hdr_byte;
   logic        tx_valid_n, tx_header_n, frame_active_n, frame_done_n;
   logic [15:0] row_count_n, col_count_n, frames_sent_n, row_final;
   logic        set_cols, set_rows, set_ovl;
   logic        rise, fall, lv_fall;

   assign rise    = fv & ~fv_d;
   assign fall    = ~fv & fv_d;
   assign lv_fall = lv_d & ~lv;

   omnivision_spi_hdr_mux u_hdr_mux (
      .hdr_idx  (hdr_idx),
      .mode_l   (mode_l),
      .rows_l   (rows_l),
      .cols_l   (cols_l),
      .hdr_byte (hdr_byte)
   );

   generate
      if (DATA_WIDTH > 8) begin : g_lsb
         logic unused_lsb;
         assign unused_lsb = ^data[DATA_WIDTH-9:0];
      end
   endgenerate

   always_comb begin
      state_n        = state;
      hdr_idx_n      = hdr_idx;
      fall_pend_n    = fall_pend;
      mode_l_n       = mode_l;
      rows_l_n       = rows_l;
      cols_l_n       = cols_l;
      tx_byte_n      = tx_byte;
      tx_valid_n     = 1'b0;
      tx_header_n    = 1'b0;
      frame_active_n = frame_active;
      frame_done_n   = 1'b0;
      row_count_n    = row_count;
      col_count_n    = col_count;
      frames_sent_n  = frames_sent;
      row_final      = row_count;
      set_cols       = 1'b0;
      set_rows       = 1'b0;
      set_ovl        = 1'b0;

      case (state)
         IDLE: begin
            if (enable_req) state_n = WAIT_FRAME;
         end
         WAIT_FRAME: begin
            if (!enable_req) begin
               state_n = IDLE;
            end else if (rise) begin
               mode_l_n       = mode;
               rows_l_n       = num_rows;
               cols_l_n       = num_cols;
               tx_byte_n      = HDR_SYNC0;
               tx_valid_n     = 1'b1;
               tx_header_n    = 1'b1;
               frame_active_n = 1'b1;
               hdr_idx_n      = 3'd1;
               row_count_n    = '0;
               col_count_n    = '0;
               fall_pend_n    = 1'b0;
               state_n        = HEADER;
            end
         end
         HEADER: begin
            tx_byte_n   = hdr_byte;
            tx_valid_n  = 1'b1;
            tx_header_n = 1'b1;
            hdr_idx_n   = hdr_idx + 3'd1;
            if (lv)   set_ovl     = 1'b1;
            if (fall) fall_pend_n = 1'b1;
            if (hdr_idx == 3'(HDR_LEN - 1)) state_n = DATA;
         end
         DATA: begin
            if (fv && lv) begin
               tx_byte_n   = data[DATA_WIDTH-1 -: 8];
               tx_valid_n  = 1'b1;
               col_count_n = sat_inc16(col_count);
            end
            if (lv_fall) begin
               if (col_count != cols_l) set_cols = 1'b1;
               row_final   = sat_inc16(row_count);
               row_count_n = row_final;
               col_count_n = '0;
            end
            // A frame that ended during the header closes here, with zero rows.
            if (fall || fall_pend) begin
               if (row_final != rows_l) set_rows = 1'b1;
               frame_done_n   = 1'b1;
               frames_sent_n  = frames_sent + 16'd1;
               frame_active_n = 1'b0;
               fall_pend_n    = 1'b0;
               state_n        = enable_req ? WAIT_FRAME : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         fv_d         <= 1'b0;
         lv_d         <= 1'b0;
         hdr_idx      <= '0;
         fall_pend    <= 1'b0;
         mode_l       <= '0;
         rows_l       <= '0;
         cols_l       <= '0;
         tx_byte      <= '0;
         tx_valid     <= 1'b0;
         tx_header    <= 1'b0;
         frame_active <= 1'b0;
         frame_done   <= 1'b0;
         row_count    <= '0;
         col_count    <= '0;
         err_cols     <= 1'b0;
         err_rows     <= 1'b0;
         err_overlap  <= 1'b0;
         frames_sent  <= '0;
      end else begin
         state        <= state_n;
         fv_d         <= fv;
         lv_d         <= lv;
         hdr_idx      <= hdr_idx_n;
         fall_pend    <= fall_pend_n;
         mode_l       <= mode_l_n;
         rows_l       <= rows_l_n;
         cols_l       <= cols_l_n;
         tx_byte      <= tx_byte_n;
         tx_valid     <= tx_valid_n;
         tx_header    <= tx_header_n;
         frame_active <= frame_active_n;
         frame_done   <= frame_done_n;
         row_count    <= row_count_n;
         col_count    <= col_count_n;
         // New errors take priority over a clear in the same cycle.
         err_cols     <= set_cols | (err_cols    & ~err_clear);
         err_rows     <= set_rows | (err_rows    & ~err_clear);
         err_overlap  <= set_ovl  | (err_overlap & ~err_clear);
         frames_sent  <= frames_sent_n;
      end
   end

endmodule

// File: doc/omnivision_spi_frame_ctrl.md
Name: omnivision_spi_frame_ctrl

Overview:
- Frame sequencer placed upstream of the Omnivision-style 2-lane SPI serializer in the imager sim path.
- Watches sensor fv/lv and emits one registered byte per pixclk: an 8-byte frame header, then one byte per pixel.
- Starts and stops only on frame boundaries, latches frame geometry, counts rows and columns, and flags geometry and protocol errors.

Parameters:
DATA_WIDTH, 10, sensor pixel width; the byte sent is data[DATA_WIDTH-1:DATA_WIDTH-8] (DATA_WIDTH >= 8)
HDR_LEN, 8, header length in bytes; fixed at 8

Ports:
pixclk  in  1  sole clock
reset  in  1  asynchronous, active-high reset
enable_req  in  1  software request to stream
mode  in  8  header mode byte (RAW8 = 8'h2A)
num_rows  in  16  expected rows per frame
num_cols  in  16  expected columns per row
fv  in  1  frame valid
lv  in  1  line valid
data  in  DATA_WIDTH  pixel data
err_clear  in  1  clears sticky errors
tx_byte  out  8  byte to serializer
tx_valid  out  1  tx_byte valid this cycle
tx_header  out  1  tx_byte is a header byte
frame_active  out  1  high from header start to fv fall
frame_done  out  1  1-cycle pulse at end of frame
row_count  out  16  rows completed in current frame
col_count  out  16  pixels in current row
err_cols  out  1  sticky: a row length differed from the latched num_cols
err_rows  out  1  sticky: a frame row count differed from the latched num_rows
err_overlap  out  1  sticky: lv high during header
frames_sent  out  16  completed frames, wraps at 16'hFFFF

Behaviour:
- All outputs are registered. On reset every output is 0, the state is IDLE and fv_d = 0. Reset mid-frame aborts immediately with no frame_done.
- fv_d is fv registered. rise = fv & !fv_d; fall = !fv & fv_d.
- IDLE:
  - enable_req = 1 -> WAIT_FRAME.
- WAIT_FRAME:
  - enable_req = 0 -> IDLE.
  - On rise: latch mode, num_rows and num_cols; tx_byte <= 8'hFF; tx_valid, tx_header and frame_active <= 1; hdr_idx <= 1; row_count and col_count <= 0; go to HEADER.
  - If fv is already high on entry, no header is sent until the next rise (no partial frames).
- HEADER:
  - hdr_idx 1..7 emits FF, 00, mode_l, rows_l[15:8], rows_l[7:0], cols_l[15:8], cols_l[7:0] on consecutive cycles.
  - tx_valid is high for exactly 8 consecutive cycles. After hdr_idx 7 -> DATA.
  - lv = 1 during HEADER: set err_overlap and drop those pixels.
  - fall during HEADER: finish all 8 header bytes, then run the end-of-frame check.
- DATA:
  - Each cycle with fv & lv: tx_byte <= data[DATA_WIDTH-1 -: 8]; tx_valid <= 1; tx_header <= 0; col_count++ (saturating). Otherwise tx_valid <= 0.
  - lv falling edge (lv_d & !lv): if col_count != cols_l, set err_cols. Then row_count++ (saturating) and col_count <= 0.
  - fall: close any open row first; when fall and the lv fall occur in the same cycle, the row is counted.
  - Then, if row_count_final != rows_l, set err_rows.
  - Then frame_done pulses for 1 cycle, frames_sent++, frame_active <= 0.
  - Next state is WAIT_FRAME if enable_req = 1, else IDLE.
- enable_req dropped mid-frame: the current frame completes normally; no truncation.
- Changes to mode, num_rows or num_cols mid-frame have no effect; values are latched at rise.
- Sticky error flags clear on err_clear. If a new error and err_clear occur in the same cycle, the error wins.
- Latency: fv/lv/data to tx_byte is 1 cycle.

Decomposition:
- Shared package:
  - state enum (IDLE, WAIT_FRAME, HEADER, DATA)
  - HDR_SYNC0 = 8'hFF, HDR_SYNC1 = 8'hFF, HDR_SYNC2 = 8'h00
  - MODE_RAW8 = 8'h2A
  - HDR_LEN = 8
- One sub-module, omnivision_spi_hdr_mux: combinational selection of the header byte from hdr_idx, mode_l, rows_l and cols_l.

Test Plan:
- enable_req = 1, mode = 2A, rows = 2, cols = 3, clean frame with 2 rows of 3 pixels, data MSBs AA, BB, CC: header FF FF 00 2A 00 02 00 03, then 6 pixel bytes; frame_done once; frames_sent = 1; no errors.
- Enable asserted while fv is already high: no tx_valid until the following rise, then the full header.
- cols = 4 but rows deliver 3 pixels; rows = 3 but the frame delivers 2 rows: err_cols = 1 and err_rows = 1, both held until err_clear; err_clear pulsed in the same cycle as a new error leaves the flag set.
- lv asserted on the 3rd header cycle: header bytes unchanged, those pixels absent, err_overlap = 1.
- enable_req dropped after row 1 of 2: row 2 is still sent, frame_done fires, state IDLE, and the next rise produces no output.
- reset asserted mid-DATA: outputs 0 the same cycle; no frame_done; after release, a full header is sent on the next rise.
